// File: rtl/note_sequencer.sv
// Song-table melody sequencer: steps through (note id, duration) entries at a
// selectable tempo and hands each note to the downstream audio_wave stage.
module note_sequencer #(
  parameter int TICK_DIV  = 4_062_500,
  parameter int SONG_LEN  = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 play,
  input  logic                 loop,
  input  logic [1:0]           tempo_sel,
  output logic [ADDR_BITS-1:0] song_addr,
  input  logic [7:0]           song_data,
  output logic [4:0]           freq_id,
  output logic                 new_f,
  output logic                 mute,
  output logic                 busy,
  output logic                 beat
);

  // state | meaning
  // IDLE  | stopped, rewound to entry 0, muted
  // LOAD  | one cycle: capture entry at song_addr, strobe new_f
  // PLAY  | count beats of the current note
  // DONE  | song finished without loop; waits for play=0

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(SONG_LEN - 1);
  localparam logic [4:0] REST_ID = 5'd31;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  state_t                 state, state_nxt;
  logic [TW-1:0]          period, period_nxt;
  logic [TW-1:0]          tick_left, tick_left_nxt;
  logic [2:0]             dur_cnt, dur_cnt_nxt;
  logic [ADDR_BITS-1:0]   song_addr_nxt;
  logic [4:0]             freq_id_nxt;
  logic                   new_f_nxt, mute_nxt, busy_nxt, beat_nxt;
  logic                   tick_tc, note_end;

  // Beat timer runs down from P-1; terminal count is the last clock of a beat.
  assign tick_tc  = (tick_left == '0);
  assign note_end = tick_tc && (dur_cnt == 3'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      song_addr <= '0;
      freq_id   <= '0;
      new_f     <= 1'b0;
      mute      <= 1'b1;
      busy      <= 1'b0;
      beat      <= 1'b0;
      period    <= '0;
      tick_left <= '0;
      dur_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      song_addr <= song_addr_nxt;
      freq_id   <= freq_id_nxt;
      new_f     <= new_f_nxt;
      mute      <= mute_nxt;
      busy      <= busy_nxt;
      beat      <= beat_nxt;
      period    <= period_nxt;
      tick_left <= tick_left_nxt;
      dur_cnt   <= dur_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (play) state_nxt = LOAD;
      LOAD: state_nxt = play ? PLAY : IDLE;
      PLAY: begin
        // Stopping wins over an end-of-note in the same cycle.
        if (!play) begin
          state_nxt = IDLE;
        end else if (note_end) begin
          state_nxt = (song_addr != LAST || loop) ? LOAD : DONE;
        end
      end
      DONE: if (!play) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    song_addr_nxt = song_addr;
    freq_id_nxt   = freq_id;
    new_f_nxt     = 1'b0;
    mute_nxt      = mute;
    beat_nxt      = 1'b0;
    period_nxt    = period;
    tick_left_nxt = tick_left;
    dur_cnt_nxt   = dur_cnt;
    busy_nxt      = (state_nxt == LOAD) || (state_nxt == PLAY);
    case (state)
      IDLE: begin
        song_addr_nxt = '0;
        mute_nxt      = 1'b1;
      end
      LOAD: begin
        if (play) begin
          freq_id_nxt   = song_data[7:3];
          dur_cnt_nxt   = song_data[2:0];
          period_nxt    = TW'(TICK_DIV >> tempo_sel);
          tick_left_nxt = TW'((TICK_DIV >> tempo_sel) - 1);
          mute_nxt      = (song_data[7:3] == REST_ID);
          new_f_nxt     = 1'b1;
        end else begin
          song_addr_nxt = '0;
          mute_nxt      = 1'b1;
        end
      end
      PLAY: begin
        if (!play) begin
          song_addr_nxt = '0;
          mute_nxt      = 1'b1;
        end else if (tick_tc) begin
          beat_nxt      = 1'b1;
          tick_left_nxt = period - 1'b1;
          if (dur_cnt != 3'd0) begin
            dur_cnt_nxt = dur_cnt - 3'd1;
          end else if (song_addr != LAST) begin
            song_addr_nxt = song_addr + 1'b1;
          end else if (loop) begin
            song_addr_nxt = '0;
          end else begin
            mute_nxt = 1'b1;
          end
        end else begin
          tick_left_nxt = tick_left - 1'b1;
        end
      end
      DONE: begin
        mute_nxt = 1'b1;
        if (!play) song_addr_nxt = '0;
      end
      default: begin
        song_addr_nxt = '0;
        mute_nxt      = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with TICK_DIV=8, SONG_LEN=4: song vectors from a
// table, strobe expectations scoreboarded in a queue, plus stop/reset corners.
module tb_note_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       play = 1'b0;
  logic       loop = 1'b0;
  logic [1:0] tempo_sel = 2'd0;
  logic [1:0] song_addr;
  logic [7:0] song_data;
  logic [4:0] freq_id;
  logic       new_f, mute, busy, beat;
  logic [3:0][7:0] rom = '0;

  assign song_data = rom[song_addr];
  always #5 clock = ~clock;

  note_sequencer #(.TICK_DIV(8), .SONG_LEN(4), .ADDR_BITS(2)) dut (
    .clock(clock), .reset(reset), .play(play), .loop(loop),
    .tempo_sel(tempo_sel), .song_addr(song_addr), .song_data(song_data),
    .freq_id(freq_id), .new_f(new_f), .mute(mute), .busy(busy), .beat(beat)
  );

  typedef struct {
    int f;
    int addr;
    int gap;
    logic m;
  } exp_t;

  typedef struct {
    logic [31:0] song;
    logic [1:0]  tempo;
    logic        lp;
    int          beats;
  } vec_t;

  typedef struct {
    int v;
    int f;
    int addr;
    int gap;
  } strobe_t;

  exp_t    sb[$];
  strobe_t st[$];
  vec_t    vt[6];
  int total = 0, bad = 0, cyc = 0, last = 0, beats = 0;

  function automatic logic [7:0] ent(input int id, input int d);
    return 8'(id * 8 + d);
  endfunction

  function automatic logic [31:0] song(input int f0, input int d0, input int f1, input int d1,
                                       input int f2, input int d2, input int f3, input int d3);
    return {ent(f3, d3), ent(f2, d2), ent(f1, d1), ent(f0, d0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add(input int v, input int f, input int a, input int g);
    strobe_t s;
    s.v = v; s.f = f; s.addr = a; s.gap = g;
    st.push_back(s);
  endtask

  task automatic expect_strobe(input int f, input int a, input int g);
    exp_t e;
    e.f = f; e.addr = a; e.gap = g; e.m = (f == 31);
    sb.push_back(e);
  endtask

  // Advance one clock, sample on the falling edge and retire strobes.
  task automatic step();
    exp_t e;
    @(negedge clock);
    cyc++;
    if (beat) beats++;
    if (new_f) begin
      if (sb.size() == 0) begin
        chk("extra_new_f", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("freq_id", freq_id, e.f);
        chk("song_addr", song_addr, e.addr);
        chk("mute_at_strobe", mute, e.m);
        chk("busy_at_strobe", busy, 1);
        chk("strobe_gap", cyc - last, e.gap);
        last = cyc;
      end
    end
  endtask

  initial begin
    int lastf;
    vt[0] = '{song(12,0, 14,1, 16,0, 17,0), 2'd0, 1'b0, 5};
    vt[1] = '{song(12,0, 14,1, 16,0, 17,0), 2'd0, 1'b1, 0};
    vt[2] = '{song(31,2,  5,0, 31,0,  6,1), 2'd0, 1'b0, 7};
    vt[3] = '{song( 3,0,  3,0,  7,1,  9,0), 2'd2, 1'b0, 5};
    vt[4] = '{song( 1,7,  2,0,  3,3,  4,0), 2'd3, 1'b0, 14};
    vt[5] = '{song(10,1, 11,0, 31,0, 12,0), 2'd1, 1'b1, 0};
    add(0,12,0,2); add(0,14,1,9); add(0,16,2,17); add(0,17,3,9);
    add(1,12,0,2); add(1,14,1,9); add(1,16,2,17); add(1,17,3,9); add(1,12,0,9); add(1,14,1,9);
    add(2,31,0,2); add(2,5,1,25); add(2,31,2,9); add(2,6,3,9);
    add(3,3,0,2); add(3,3,1,3); add(3,7,2,3); add(3,9,3,5);
    add(4,1,0,2); add(4,2,1,9); add(4,3,2,2); add(4,4,3,5);
    add(5,10,0,2); add(5,11,1,9); add(5,31,2,5); add(5,12,3,5); add(5,10,0,5);

    #1 reset = 1'b0;
    #2;
    chk("rst_song_addr", song_addr, 0);
    chk("rst_freq_id", freq_id, 0);
    chk("rst_new_f", new_f, 0);
    chk("rst_mute", mute, 1);
    chk("rst_busy", busy, 0);
    chk("rst_beat", beat, 0);
    @(negedge clock);
    reset = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      play = 1'b0;
      repeat (3) step();
      rom = vt[v].song;
      tempo_sel = vt[v].tempo;
      loop = vt[v].lp;
      lastf = 0;
      foreach (st[i]) begin
        if (st[i].v == v) begin
          expect_strobe(st[i].f, st[i].addr, st[i].gap);
          lastf = st[i].f;
        end
      end
      beats = 0;
      play = 1'b1;
      last = cyc;
      for (int k = 0; k < 400 && sb.size() > 0; k++) step();
      chk("strobes_pending", sb.size(), 0);
      sb.delete();
      if (!vt[v].lp) begin
        repeat (80) step();
        chk("done_busy", busy, 0);
        chk("done_mute", mute, 1);
        chk("done_freq_held", freq_id, lastf);
        chk("beat_count", beats, vt[v].beats);
      end else begin
        play = 1'b0;
        step();
        chk("stop_busy", busy, 0);
        chk("stop_addr", song_addr, 0);
        chk("stop_mute", mute, 1);
      end
    end

    // play dropped exactly at the end-of-note terminal count
    play = 1'b0;
    repeat (3) step();
    rom = song(12,0, 14,0, 16,0, 17,0);
    tempo_sel = 2'd0;
    loop = 1'b0;
    expect_strobe(12, 0, 2);
    play = 1'b1;
    last = cyc;
    repeat (2) step();
    chk("tc_first_strobe", sb.size(), 0);
    repeat (7) step();
    play = 1'b0;
    step();
    chk("tc_stop_busy", busy, 0);
    chk("tc_stop_addr", song_addr, 0);
    chk("tc_stop_mute", mute, 1);
    chk("tc_stop_new_f", new_f, 0);
    repeat (20) step();
    expect_strobe(12, 0, 2);
    play = 1'b1;
    last = cyc;
    repeat (2) step();
    chk("tc_restart_strobe", sb.size(), 0);
    sb.delete();

    // asynchronous reset in the middle of the second note
    play = 1'b0;
    repeat (3) step();
    expect_strobe(12, 0, 2);
    expect_strobe(14, 1, 9);
    play = 1'b1;
    last = cyc;
    for (int k = 0; k < 40 && sb.size() > 0; k++) step();
    chk("ar_strobes_pending", sb.size(), 0);
    sb.delete();
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    chk("ar_song_addr", song_addr, 0);
    chk("ar_freq_id", freq_id, 0);
    chk("ar_mute", mute, 1);
    chk("ar_busy", busy, 0);
    chk("ar_new_f", new_f, 0);
    play = 1'b0;
    step();
    reset = 1'b1;
    repeat (3) step();
    chk("ar_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
